// File: rtl/fixed_point_sat_accum.sv
// Saturating signed fixed-point accumulator: sums LEN operands (add or
// subtract each), clamps at every step, and holds the result with a sticky
// overflow flag until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. in_ready is 1 only in ACCUM with rst low and never looks at
// in_valid. out_valid is 1 only in HOLD and stays up with out_sum and
// out_overflow stable until out_ready is seen.
module fixed_point_sat_accum #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow
);

    // Parameter sanity; FRAC only describes the number format.
    if (WIDTH < 4 || FRAC < 0 || FRAC >= WIDTH || LEN < 1) begin : g_bad_params
        $error("fixed_point_sat_accum: illegal WIDTH/FRAC/LEN combination");
    end

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    // Clamp limits, widened by two bits so acc +/- data never wraps.
    localparam logic signed [WIDTH+1:0] MAX_POS = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] MIN_NEG = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     acc, acc_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic                 sticky, sticky_nxt;
    logic [WIDTH-1:0]     sum_nxt;
    logic                 ovf_nxt;

    logic signed [WIDTH+1:0] acc_ext;
    logic signed [WIDTH+1:0] data_ext;
    logic signed [WIDTH+1:0] sum_raw;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    step_sat;
    logic [WIDTH-1:0]        step_val;

    assign in_ready  = (state == ACCUM) && !rst;
    assign out_valid = (state == HOLD);

    // One saturating step: widened add/subtract, then clamp to the WIDTH range.
    always_comb begin
        acc_ext  = {{2{acc[WIDTH-1]}}, acc};
        data_ext = {{2{in_data[WIDTH-1]}}, in_data};
        sum_raw  = in_sub ? (acc_ext - data_ext) : (acc_ext + data_ext);
        sat_hi   = (sum_raw > MAX_POS);
        sat_lo   = (sum_raw < MIN_NEG);
        step_sat = sat_hi || sat_lo;
        if (sat_hi) begin
            step_val = MAX_POS[WIDTH-1:0];
        end else if (sat_lo) begin
            step_val = MIN_NEG[WIDTH-1:0];
        end else begin
            step_val = sum_raw[WIDTH-1:0];
        end
    end

    // Next-state logic: clear beats both handshakes; last term loads the result.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        sticky_nxt = sticky;
        sum_nxt    = out_sum;
        ovf_nxt    = out_overflow;
        if (clear) begin
            state_nxt  = ACCUM;
            acc_nxt    = '0;
            count_nxt  = '0;
            sticky_nxt = 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                state_nxt = ACCUM;
            end
        end else if (in_valid) begin
            if (count == LAST) begin
                sum_nxt    = step_val;
                ovf_nxt    = sticky || step_sat;
                state_nxt  = HOLD;
                acc_nxt    = '0;
                count_nxt  = '0;
                sticky_nxt = 1'b0;
            end else begin
                acc_nxt    = step_val;
                count_nxt  = count + CW'(1);
                sticky_nxt = sticky || step_sat;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            sticky       <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            count        <= count_nxt;
            sticky       <= sticky_nxt;
            out_sum      <= sum_nxt;
            out_overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fixed_point_sat_accum.sv
// Bench for fixed_point_sat_accum: one LEN=4 instance and one LEN=1
// instance, each followed cycle by cycle by a transaction-level model and
// pinned by hand-computed literal results.
module tb_fixed_point_sat_accum;

    localparam int W = 32;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    // LEN=4 instance signals
    logic         a_clear = 1'b0, a_in_valid = 1'b0, a_in_sub = 1'b0, a_out_ready = 1'b0;
    logic [W-1:0] a_in_data = '0;
    logic         a_in_ready, a_out_valid, a_out_overflow;
    logic [W-1:0] a_out_sum;

    // LEN=1 instance signals
    logic         b_clear = 1'b0, b_in_valid = 1'b0, b_in_sub = 1'b0, b_out_ready = 1'b1;
    logic [W-1:0] b_in_data = '0;
    logic         b_in_ready, b_out_valid, b_out_overflow;
    logic [W-1:0] b_out_sum;

    always #5 clk = ~clk;

    fixed_point_sat_accum #(.WIDTH(W), .FRAC(16), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sub(a_in_sub),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .out_overflow(a_out_overflow)
    );

    fixed_point_sat_accum #(.WIDTH(W), .FRAC(16), .LEN(1)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sub(b_in_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_overflow(b_out_overflow)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        longint acc;     // running sum as a plain integer
        int     terms;   // terms taken so far in this accumulation
        bit     sticky;
        bit     hold;    // a result is waiting for the consumer
        longint sum;
        bit     ovf;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;

    function automatic model_t step(model_t m, int len, bit r, bit clr, bit iv, bit sub,
                                    logic [W-1:0] d, bit ordy);
        model_t n = m;
        longint v;
        longint sd;
        bit sat;
        if (r) return model_t'(0);
        if (clr) begin
            n.acc = 0; n.terms = 0; n.sticky = 0; n.hold = 0;
            return n;
        end
        if (m.hold) begin
            if (ordy) n.hold = 0;
            return n;
        end
        if (iv) begin
            sd = longint'($signed(d));
            v = sub ? (m.acc - sd) : (m.acc + sd);
            sat = 0;
            if (v > MAXP) begin v = MAXP; sat = 1; end
            else if (v < MINN) begin v = MINN; sat = 1; end
            if (m.terms + 1 == len) begin
                n.sum = v; n.ovf = m.sticky | sat; n.hold = 1;
                n.acc = 0; n.terms = 0; n.sticky = 0;
            end else begin
                n.acc = v; n.terms = m.terms + 1; n.sticky = m.sticky | sat;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 4, rst, a_clear, a_in_valid, a_in_sub, a_in_data, a_out_ready);
        mb <= step(mb, 1, rst, b_clear, b_in_valid, b_in_sub, b_in_data, b_out_ready);
    end

    // ---------------- scoreboard ----------------
    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Every cycle, away from the active edge, compare both DUTs with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_in_ready",     64'(a_in_ready),     64'(!ma.hold && !rst));
            check("a_out_valid",    64'(a_out_valid),    64'(ma.hold));
            check("a_out_sum",      64'(a_out_sum),      64'(ma.sum[W-1:0]));
            check("a_out_overflow", 64'(a_out_overflow), 64'(ma.ovf));
            check("b_in_ready",     64'(b_in_ready),     64'(!mb.hold && !rst));
            check("b_out_valid",    64'(b_out_valid),    64'(mb.hold));
            check("b_out_sum",      64'(b_out_sum),      64'(mb.sum[W-1:0]));
            check("b_out_overflow", 64'(b_out_overflow), 64'(mb.ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input bit sub, input logic [W-1:0] d);
        bit done = 1'b0;
        a_in_valid = 1'b1; a_in_sub = sub; a_in_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = a_in_ready;
            tick();
        end
        a_in_valid = 1'b0;
        if (!done) check("send_a_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_b(input bit sub, input logic [W-1:0] d);
        bit done = 1'b0;
        b_in_valid = 1'b1; b_in_sub = sub; b_in_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = b_in_ready;
            tick();
        end
        b_in_valid = 1'b0;
        if (!done) check("send_b_timeout", 64'(0), 64'(1));
    endtask

    task automatic expect_a(input string name, input logic [W-1:0] sum, input bit ovf);
        check({name, "_valid"}, 64'(a_out_valid), 64'(1));
        check({name, "_sum"}, 64'(a_out_sum), 64'(sum));
        check({name, "_ovf"}, 64'(a_out_overflow), 64'(ovf));
        check({name, "_model_sum"}, 64'(ma.sum[W-1:0]), 64'(sum));
    endtask

    task automatic take_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("take_a_valid_low", 64'(a_out_valid), 64'(0));
        check("take_a_ready_high", 64'(a_in_ready), 64'(1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_sum", 64'(a_out_sum), 64'(0));
        check("rst_out_ovf", 64'(a_out_overflow), 64'(0));
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        rst = 1'b0;
        tick();

        // 1.5 + 0.5 - 1.0 + 1.0 = 2.0
        send_a(1'b0, 32'h0001_8000);
        send_a(1'b0, 32'h0000_8000);
        send_a(1'b0, 32'hFFFF_0000);
        send_a(1'b0, 32'h0001_0000);
        expect_a("basic", 32'h0002_0000, 1'b0);
        take_a();

        // Positive saturation at step 2, later terms continue from the clamp.
        send_a(1'b0, 32'h7FFF_0000);
        send_a(1'b0, 32'h7FFF_0000);
        send_a(1'b1, 32'h0001_0000);
        send_a(1'b0, 32'h0000_0000);
        expect_a("possat", 32'h7FFE_FFFF, 1'b1);

        // Hold the result with an operand pending; nothing may be consumed.
        a_in_valid = 1'b1; a_in_sub = 1'b0; a_in_data = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_in_ready", 64'(a_in_ready), 64'(0));
            expect_a("hold", 32'h7FFE_FFFF, 1'b1);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_in_valid = 1'b0;
        check("hold_release_valid", 64'(a_out_valid), 64'(0));
        check("hold_release_ready", 64'(a_in_ready), 64'(1));

        // clear with a same-cycle operand: partial sum and operand dropped.
        send_a(1'b0, 32'h0005_0000);
        send_a(1'b0, 32'h0005_0000);
        a_in_valid = 1'b1; a_in_data = 32'h0007_0000; a_clear = 1'b1;
        tick();
        a_in_valid = 1'b0; a_clear = 1'b0;
        check("clear_valid", 64'(a_out_valid), 64'(0));
        check("clear_keeps_sum", 64'(a_out_sum), 64'(32'h7FFE_FFFF));
        for (int i = 0; i < 4; i++) send_a(1'b0, 32'h0001_0000);
        expect_a("after_clear", 32'h0004_0000, 1'b0);
        take_a();

        // Negative saturation: MIN - 1 clamps, then +0x10.
        send_a(1'b0, 32'h8000_0000);
        send_a(1'b1, 32'h0000_0001);
        send_a(1'b0, 32'h0000_0010);
        send_a(1'b0, 32'h0000_0000);
        expect_a("negsat", 32'h8000_0010, 1'b1);
        take_a();

        // Reset mid-accumulation discards the partial sum.
        send_a(1'b0, 32'h0003_0000);
        send_a(1'b0, 32'h0003_0000);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 64'(a_out_valid), 64'(0));
        check("rst_mid_sum", 64'(a_out_sum), 64'(0));
        check("rst_mid_ovf", 64'(a_out_overflow), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_a(1'b0, 32'h0001_0000);
        expect_a("after_rst", 32'h0004_0000, 1'b0);

        // Reset while a result is held.
        rst = 1'b1;
        tick();
        check("rst_hold_valid", 64'(a_out_valid), 64'(0));
        check("rst_hold_sum", 64'(a_out_sum), 64'(0));
        check("rst_hold_ovf", 64'(a_out_overflow), 64'(0));
        rst = 1'b0;
        tick();

        // LEN=1: each operand is a full result.
        send_b(1'b1, 32'h8000_0000);
        check("len1_neg_min_valid", 64'(b_out_valid), 64'(1));
        check("len1_neg_min_sum", 64'(b_out_sum), 64'(32'h7FFF_FFFF));
        check("len1_neg_min_ovf", 64'(b_out_overflow), 64'(1));
        send_b(1'b0, 32'h8000_0000);
        check("len1_min_sum", 64'(b_out_sum), 64'(32'h8000_0000));
        check("len1_min_ovf", 64'(b_out_overflow), 64'(0));
        check("len1_model_sum", 64'(mb.sum[W-1:0]), 64'(32'h8000_0000));
        send_b(1'b1, 32'h0000_0005);
        check("len1_sub_sum", 64'(b_out_sum), 64'(32'hFFFF_FFFB));
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
